// File: rtl/md_unit_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide unit: D/E instruction words,
// E-stage operands, and the unit's status, stall and HI/LO result signals.
interface md_unit_ctrl_if;
  logic [31:0] ir_d;
  logic [31:0] ir_e;
  logic [31:0] rs_e;
  logic [31:0] rt_e;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  modport master (
    output ir_d, ir_e, rs_e, rt_e,
    input  start, busy, stall_md, hi, lo, md_out
  );

  modport slave (
    input  ir_d, ir_e, rs_e, rt_e,
    output start, busy, stall_md, hi, lo, md_out
  );
endinterface

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer with HI/LO registers and D-stage stall request.
// Optional MD_MADD_EN adds madd/maddu/msub/msubu accumulate-class operations.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  md_unit_ctrl_if.slave md
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        commit_q, commit_d;

  function automatic logic md_class(input logic [31:0] ir);
    logic r;
    // special funcs 01x0xx cover mfhi/mthi/mflo/mtlo and mult/multu/div/divu
    r = (ir[31:26] == 6'b000000) && (ir[5:4] == 2'b01) && !ir[2];
`ifdef MD_MADD_EN
    r = r | ((ir[31:26] == 6'b011100) && (ir[5:3] == 3'b000) && !ir[1]);
`endif
    return r;
  endfunction

  logic [5:0] op_e, fn_e;
  logic       special_e;
  logic       is_mult, is_multu, is_div, is_divu;
  logic       is_mfhi, is_mthi, is_mflo, is_mtlo;
  logic       is_madd, madd_signed, madd_sub;
  logic       mul_start, div_start;
  logic       unused_ir;

  assign op_e      = md.ir_e[31:26];
  assign fn_e      = md.ir_e[5:0];
  assign special_e = (op_e == 6'b000000);
  assign is_mult   = special_e && (fn_e == 6'b011000);
  assign is_multu  = special_e && (fn_e == 6'b011001);
  assign is_div    = special_e && (fn_e == 6'b011010);
  assign is_divu   = special_e && (fn_e == 6'b011011);
  assign is_mfhi   = special_e && (fn_e == 6'b010000);
  assign is_mthi   = special_e && (fn_e == 6'b010001);
  assign is_mflo   = special_e && (fn_e == 6'b010010);
  assign is_mtlo   = special_e && (fn_e == 6'b010011);

`ifdef MD_MADD_EN
  assign is_madd     = (op_e == 6'b011100) && (fn_e[5:3] == 3'b000) && !fn_e[1];
  assign madd_signed = !fn_e[0];
  assign madd_sub    = fn_e[2];
`else
  assign is_madd     = 1'b0;
  assign madd_signed = 1'b0;
  assign madd_sub    = 1'b0;
`endif

  assign mul_start = is_mult | is_multu | is_madd;
  assign div_start = is_div | is_divu;
  assign unused_ir = ^{md.ir_d[25:6], md.ir_e[25:6]};

  logic [63:0]        prod_s, prod_u, prod_m, acc;
  logic signed [32:0] dvd_s, dvs_s, quo_s, rem_s;
  logic [31:0]        dvs_u, quo_u, rem_u;
  logic               rt_zero;

  assign rt_zero = (md.rt_e == '0);
  assign prod_s  = {{32{md.rs_e[31]}}, md.rs_e} * {{32{md.rt_e[31]}}, md.rt_e};
  assign prod_u  = {32'b0, md.rs_e} * {32'b0, md.rt_e};
  assign prod_m  = madd_signed ? prod_s : prod_u;
  assign acc     = {hi_q, lo_q};

  // 33-bit signed divide keeps -2^31 / -1 well defined; a zero divisor is
  // replaced by 1 so the divider never sees it (result is discarded anyway).
  assign dvd_s = $signed({md.rs_e[31], md.rs_e});
  assign dvs_s = rt_zero ? 33'sd1 : $signed({md.rt_e[31], md.rt_e});
  assign quo_s = dvd_s / dvs_s;
  assign rem_s = dvd_s % dvs_s;
  assign dvs_u = rt_zero ? 32'd1 : md.rt_e;
  assign quo_u = md.rs_e / dvs_u;
  assign rem_u = md.rs_e % dvs_u;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pend_d   = pend_q;
    commit_d = commit_q;
    case (state_q)
      IDLE: begin
        if (mul_start || div_start) begin
          state_d  = RUN;
          cnt_d    = mul_start ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          commit_d = !(div_start && rt_zero);
          if (is_mult)       pend_d = prod_s;
          else if (is_multu) pend_d = prod_u;
          else if (is_div)   pend_d = {rem_s[31:0], quo_s[31:0]};
          else if (is_divu)  pend_d = {rem_u, quo_u};
          else               pend_d = madd_sub ? (acc - prod_m) : (acc + prod_m);
        end else begin
          if (is_mthi) hi_d = md.rs_e;
          if (is_mtlo) lo_d = md.rs_e;
        end
      end
      RUN: begin
        // a start seen here is ignored: the running operation is left intact
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (commit_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pend_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
    end
  end

  assign md.start    = mul_start | div_start;
  assign md.busy     = (state_q == RUN);
  assign md.stall_md = md_class(md.ir_d) && (md.start || md.busy);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_out   = is_mfhi ? hi_q : (is_mflo ? lo_q : '0);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Randomized bench for md_unit_ctrl against a cycle-indexed reference model;
// build with +define+MD_MADD_EN to exercise the accumulate-class operations.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_ctrl_if bus ();

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  typedef enum int {K_NONE, K_MULT, K_MULTU, K_DIV, K_DIVU, K_MFHI, K_MTHI,
                    K_MFLO, K_MTLO, K_MADD, K_MADDU, K_MSUB, K_MSUBU} kind_e;

  localparam logic [31:0] MULT_I  = 32'h0000_0018;
  localparam logic [31:0] MULTU_I = 32'h0000_0019;
  localparam logic [31:0] DIV_I   = 32'h0000_001A;
  localparam logic [31:0] DIVU_I  = 32'h0000_001B;
  localparam logic [31:0] MFHI_I  = 32'h0000_0010;
  localparam logic [31:0] MTHI_I  = 32'h0000_0011;
  localparam logic [31:0] MFLO_I  = 32'h0000_0012;
  localparam logic [31:0] MTLO_I  = 32'h0000_0013;
  localparam logic [31:0] ADDU_I  = 32'h0000_0021;
  localparam logic [31:0] MADDU_I = 32'h7000_0001;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  bit          m_commit, m_active;
  int          m_end, cyc;

  logic        s_start, s_busy, s_stall;
  logic [31:0] s_hi, s_lo, s_md;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic kind_e kind(input logic [31:0] ir);
    if (ir[31:26] == 6'b000000) begin
      case (ir[5:0])
        6'b011000: return K_MULT;
        6'b011001: return K_MULTU;
        6'b011010: return K_DIV;
        6'b011011: return K_DIVU;
        6'b010000: return K_MFHI;
        6'b010001: return K_MTHI;
        6'b010010: return K_MFLO;
        6'b010011: return K_MTLO;
        default:   return K_NONE;
      endcase
    end
`ifdef MD_MADD_EN
    if (ir[31:26] == 6'b011100) begin
      case (ir[5:0])
        6'b000000: return K_MADD;
        6'b000001: return K_MADDU;
        6'b000100: return K_MSUB;
        6'b000101: return K_MSUBU;
        default:   return K_NONE;
      endcase
    end
`endif
    return K_NONE;
  endfunction

  function automatic bit starts(input kind_e k);
    return k inside {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MADD, K_MADDU, K_MSUB, K_MSUBU};
  endfunction

  function automatic logic [63:0] ref_result(input kind_e k, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (k)
      K_MULT:  return sa * sb;
      K_MULTU: return ua * ub;
      K_DIV: begin
        if (b == 0) return '0;
        q = sa / sb;
        r = sa - q * sb;
        return {r[31:0], q[31:0]};
      end
      K_DIVU: begin
        if (b == 0) return '0;
        uq = ua / ub;
        ur = ua - uq * ub;
        return {ur[31:0], uq[31:0]};
      end
      K_MADD:  return acc + sa * sb;
      K_MADDU: return acc + ua * ub;
      K_MSUB:  return acc - sa * sb;
      K_MSUBU: return acc - ua * ub;
      default: return '0;
    endcase
  endfunction

  task automatic step(input logic [31:0] ird, input logic [31:0] ire,
                      input logic [31:0] rs, input logic [31:0] rt, input logic rst);
    kind_e       ke;
    logic        e_start;
    logic [31:0] e_md;
    @(negedge clk);
    bus.ir_d = ird;
    bus.ir_e = ire;
    bus.rs_e = rs;
    bus.rt_e = rt;
    reset    = rst;
    #1;
    ke      = kind(ire);
    e_start = starts(ke);
    e_md    = (ke == K_MFHI) ? m_hi : ((ke == K_MFLO) ? m_lo : 32'h0);
    check("start",    64'(bus.start),    64'(e_start));
    check("busy",     64'(bus.busy),     64'(m_active));
    check("stall_md", 64'(bus.stall_md), 64'((kind(ird) != K_NONE) && (e_start || m_active)));
    check("hi",       64'(bus.hi),       64'(m_hi));
    check("lo",       64'(bus.lo),       64'(m_lo));
    check("md_out",   64'(bus.md_out),   64'(e_md));
    s_start = bus.start;
    s_busy  = bus.busy;
    s_stall = bus.stall_md;
    s_hi    = bus.hi;
    s_lo    = bus.lo;
    s_md    = bus.md_out;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_active = 0; m_commit = 0;
    end else if (m_active) begin
      if (cyc == m_end) begin
        m_active = 0;
        if (m_commit) {m_hi, m_lo} = m_pend;
      end
    end else if (e_start) begin
      m_pend   = ref_result(ke, rs, rt, {m_hi, m_lo});
      m_commit = !((ke == K_DIV || ke == K_DIVU) && rt == 0);
      m_active = 1;
      m_end    = cyc + ((ke == K_DIV || ke == K_DIVU) ? DIV_N : MULT_N);
    end else if (ke == K_MTHI) begin
      m_hi = rs;
    end else if (ke == K_MTLO) begin
      m_lo = rs;
    end
    cyc++;
  endtask

  // Steps with a bubble in E until busy is seen low; nbusy counts busy cycles.
  task automatic wait_idle(input logic [31:0] ird, output int nbusy);
    bit done;
    nbusy = 0;
    done  = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      step(ird, 32'h0, 32'h0, 32'h0, 1'b0);
      if (s_busy) nbusy++;
      else done = 1;
    end
    if (!done) check("idle_timeout", 64'd1, 64'd0);
  endtask

  function automatic logic [31:0] rand_ir(input bit allow_md);
    logic [31:0] r, ir;
    logic [5:0]  fn;
    r = $urandom;
    case ($urandom_range(0, 13))
      0:  fn = 6'b011000;
      1:  fn = 6'b011001;
      2:  fn = 6'b011010;
      3:  fn = 6'b011011;
      4:  fn = 6'b010000;
      5:  fn = 6'b010001;
      6:  fn = 6'b010010;
      7:  fn = 6'b010011;
      8:  fn = 6'b100001;
      9:  fn = 6'b010100;
      default: fn = 6'b011100;
    endcase
    ir = {6'b000000, r[25:6], fn};
    if (fn == 6'b011100) begin
      case (r[1:0])
        2'd0: ir = {6'b011100, r[25:6], 6'b000000};
        2'd1: ir = {6'b011100, r[25:6], 6'b000001};
        2'd2: ir = {6'b011100, r[25:6], 6'b000100};
        default: ir = {6'b011100, r[25:6], 6'b000101};
      endcase
    end
    if (r[31:29] == 3'b000) ir = '0;
    if (r[28:26] == 3'b111) ir = {6'b100011, r[25:0]};
    if (!allow_md && kind(ir) != K_NONE) ir = '0;
    return ir;
  endfunction

  initial begin
    int          nb;
    logic [31:0] ird, ire, rs, rt;
    logic        rst;

    bus.ir_d = '0; bus.ir_e = '0; bus.rs_e = '0; bus.rt_e = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    m_hi = '0; m_lo = '0; m_pend = '0; m_active = 0; m_commit = 0; m_end = 0; cyc = 0;

    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("idle_hi", 64'(s_hi), 64'h0);
    check("idle_lo", 64'(s_lo), 64'h0);
    check("idle_busy", 64'(s_busy), 64'h0);

    step(MFLO_I, MULT_I, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_stall_start", 64'(s_stall), 64'd1);
    wait_idle(MFLO_I, nb);
    check("mult_busy_len", 64'(nb), 64'(MULT_N));
    check("mult_hi", 64'(s_hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(s_lo), 64'hFFFF_FFFA);
    step(32'h0, MFLO_I, 32'h0, 32'h0, 1'b0);
    check("mflo_out", 64'(s_md), 64'hFFFF_FFFA);

    step(32'h0, MULTU_I, 32'hFFFF_FFFE, 32'd3, 1'b0);
    step(ADDU_I, 32'h0, 32'h0, 32'h0, 1'b0);
    check("addu_no_stall", 64'(s_stall), 64'd0);
    wait_idle(32'h0, nb);
    check("multu_busy_rest", 64'(nb), 64'(MULT_N - 1));
    check("multu_hi", 64'(s_hi), 64'h0000_0002);
    check("multu_lo", 64'(s_lo), 64'hFFFF_FFFA);

    step(32'h0, DIV_I, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_idle(MFHI_I, nb);
    check("div_busy_len", 64'(nb), 64'(DIV_N));
    check("div_lo", 64'(s_lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(s_hi), 64'hFFFF_FFFF);

    step(32'h0, DIVU_I, 32'd7, 32'd0, 1'b0);
    wait_idle(32'h0, nb);
    check("div0_busy_len", 64'(nb), 64'(DIV_N));
    check("div0_hi_kept", 64'(s_hi), 64'hFFFF_FFFF);
    check("div0_lo_kept", 64'(s_lo), 64'hFFFF_FFFD);

    step(MFHI_I, MTHI_I, 32'h1234_5678, 32'h0, 1'b0);
    step(32'h0, MFHI_I, 32'h0, 32'h0, 1'b0);
    check("mthi_hi", 64'(s_hi), 64'h1234_5678);
    check("mfhi_out", 64'(s_md), 64'h1234_5678);

    step(32'h0, DIV_I, 32'd100, 32'd7, 1'b0);
    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_hi", 64'(s_hi), 64'h0);
    check("rst_lo", 64'(s_lo), 64'h0);

    step(32'h0, MTHI_I, 32'h0, 32'h0, 1'b0);
    step(32'h0, MTLO_I, 32'hFFFF_FFFF, 32'h0, 1'b0);
    step(32'h0, MADDU_I, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
    check("maddu_start", 64'(s_start), 64'd1);
    wait_idle(32'h0, nb);
    check("maddu_busy_len", 64'(nb), 64'(MULT_N));
    check("maddu_hi", 64'(s_hi), 64'h0000_0001);
    check("maddu_lo", 64'(s_lo), 64'h0000_0000);
`else
    check("maddu_no_start", 64'(s_start), 64'd0);
    step(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    check("maddu_hi_kept", 64'(s_hi), 64'h0000_0000);
    check("maddu_lo_kept", 64'(s_lo), 64'hFFFF_FFFF);
`endif

    for (int i = 0; i < 1500; i++) begin
      ird = rand_ir(1'b1);
      ire = rand_ir(!m_active);
      rs  = $urandom;
      rt  = $urandom;
      if ($urandom_range(0, 7) == 0) rt = '0;
      if ($urandom_range(0, 3) == 0) rs = 32'($urandom_range(0, 20)) - 32'd10;
      rst = ($urandom_range(0, 199) == 0);
      step(ird, ire, rs, rt, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Sequencer and scheduler for the shared multiply/divide resource and its HI/LO registers in the 5-stage MIPS pipeline.
- Launches mult/div operations issued from the E stage and holds a busy counter for the modelled latency.
- Commits results to HI/LO and serves mfhi/mflo/mthi/mtlo.
- Raises a stall request so that D-stage HI/LO-class instructions wait while the unit is occupied; this request is ORed with the existing hazard stall.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd-class when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- ir_d  in  32  instruction currently in D stage.
- ir_e  in  32  instruction currently in E stage; a bubble is 0.
- rs_e  in  32  forwarded rs operand in E.
- rt_e  in  32  forwarded rt operand in E.
- start  out  1  combinational; a mult/multu/div/divu (or madd-class) is in E this cycle.
- busy  out  1  registered; an operation is in progress.
- stall_md  out  1  combinational stall request to D.
- hi  out  32  HI register.
- lo  out  32  LO register.
- md_out  out  32  combinational; hi if ir_e is mfhi, lo if ir_e is mflo, else 0.

Behaviour:
- Decode uses op=000000 with these func values: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- md-class = all eight of the above, plus madd-class when enabled.
- Reset clears hi, lo, busy, the counter and the pending result registers.
  - A reset during an operation aborts it; no commit occurs.
- start: on the edge that ends the start cycle:
  - latch the pending result: mult = signed 64-bit product, multu = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu is the unsigned equivalent.
  - counter <= N (MULT_CYCLES or DIV_CYCLES); busy <= 1.
- Busy timing:
  - busy stays high for exactly N cycles after the start cycle.
  - The counter decrements on each edge while busy.
  - On the edge where the counter goes 1 -> 0: busy <= 0 and {hi,lo} <= pending.
  - New hi/lo values are visible in the first cycle after busy falls.
- Divide by zero (div/divu with rt_e == 0): busy runs the full DIV_CYCLES, then hi and lo remain unchanged (no commit).
- mthi/mtlo in E (start = 0, busy = 0 guaranteed by stall_md): hi <= rs_e or lo <= rs_e on that edge.
- stall_md = (ir_d is md-class) && (start || busy).
  - Non-md instructions in D never stall on this unit.
- start while busy: not reachable, because stall_md prevents it. Defensive rule: ignore the start and keep the running operation unchanged.
- No state machine beyond IDLE (busy = 0) and RUN (busy = 1, counter 1..N):
  - IDLE -> RUN on start.
  - RUN -> IDLE when the counter reaches 0.
  - RUN -> IDLE on reset.

Optional Feature:
- Macro MD_MADD_EN.
- When defined:
  - Decodes op=011100 with func 000000 madd, 000001 maddu, 000100 msub, 000101 msubu.
  - These are md-class and take MULT_CYCLES.
  - Pending = {hi,lo} +/- the signed or unsigned product, computed from the hi/lo value at the start cycle, modulo 2^64.
- When undefined: these encodings are not md-class, never assert start, and leave hi/lo untouched.

Test Plan:
- Reset, then idle: hi = lo = 0, busy = 0, stall_md = 0, md_out = 0.
- mult with rs_e = 0xFFFFFFFE (-2), rt_e = 3 -> busy high 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA. multu with the same operands -> hi = 0x00000002, lo = 0xFFFFFFFA.
- div with rs_e = -7, rt_e = 2 -> after 10 busy cycles lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. divu with 7 / 0 -> busy 10 cycles, hi/lo unchanged.
- mult in E with mflo in D -> stall_md = 1 for the start cycle plus 5 busy cycles. mflo reaches E the cycle busy falls; md_out = new lo. An addu in D during busy -> stall_md = 0.
- mthi with rs_e = 0x12345678, then mfhi next -> hi = 0x12345678, md_out = 0x12345678. Reset asserted on the 3rd cycle of a div -> busy = 0 next cycle and hi = lo = 0.
- With MD_MADD_EN: hi = 0, lo = 0xFFFFFFFF, maddu with 1 * 1 -> hi = 1, lo = 0. Without MD_MADD_EN: the same encoding gives start = 0, hi/lo unchanged.
